// File: rtl/sys_array_tile_sched.sv
// Tile scheduler: walks C = A*B in output tiles of up to ARRAY_W x ARRAY_L and
// K-chunks of up to ARRAY_K, issuing one tile pass at a time to the array.
module sys_array_tile_sched #(
  parameter int ARRAY_W = 4,
  parameter int ARRAY_L = 4,
  parameter int ARRAY_K = 4,
  parameter int DIM_W   = 16
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           start,
  input  logic                           abort,
  input  logic [DIM_W-1:0]               ARRAY_A_W,
  input  logic [DIM_W-1:0]               ARRAY_A_L,
  input  logic [DIM_W-1:0]               ARRAY_W_W,
  input  logic [DIM_W-1:0]               ARRAY_W_L,
  input  logic                           tile_done,
  output logic                           tile_start,
  output logic [DIM_W-1:0]               row_off,
  output logic [DIM_W-1:0]               col_off,
  output logic [DIM_W-1:0]               k_off,
  output logic [$clog2(ARRAY_W+1)-1:0]   tile_rows,
  output logic [$clog2(ARRAY_L+1)-1:0]   tile_cols,
  output logic [$clog2(ARRAY_K+1)-1:0]   tile_k,
  output logic                           acc_clear,
  output logic                           acc_store,
  output logic                           busy,
  output logic                           ready,
  output logic                           err,
  output logic [DIM_W-1:0]               tile_cnt,
  output logic [2:0]                     state_dbg
);
  localparam int RW = $clog2(ARRAY_W + 1);
  localparam int CW = $clog2(ARRAY_L + 1);
  localparam int KW = $clog2(ARRAY_K + 1);

  // Handshake: tile_start pulses for exactly one cycle (ISSUE) with the tile
  // fields valid; the array answers with a one-cycle tile_done, honoured only
  // in WAIT. Fields hold their value until the next tile_start.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_NEXT  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t state, state_nx;

  logic [DIM_W-1:0] m_r, k_r, ww_r, n_r;
  logic [DIM_W:0]   row_sum, col_sum, k_sum;
  logic             row_wrap, col_wrap, k_wrap, dims_bad, take_start;
  logic [DIM_W-1:0] nrow, ncol, nk;
  logic [DIM_W:0]   rem_r, rem_c, rem_k;
  logic [RW-1:0]    n_rows;
  logic [CW-1:0]    n_cols;
  logic [KW-1:0]    n_k;

  assign take_start = start && !abort && (state == S_IDLE || state == S_DONE);
  assign dims_bad   = (m_r == '0) || (k_r == '0) || (n_r == '0) || (ww_r != k_r);

  // Sums carry one extra bit so wrap detection is exact near 2^DIM_W-1.
  assign row_sum  = {1'b0, row_off} + (DIM_W+1)'(ARRAY_W);
  assign col_sum  = {1'b0, col_off} + (DIM_W+1)'(ARRAY_L);
  assign k_sum    = {1'b0, k_off}   + (DIM_W+1)'(ARRAY_K);
  assign row_wrap = row_sum >= {1'b0, m_r};
  assign col_wrap = col_sum >= {1'b0, n_r};
  assign k_wrap   = k_sum   >= {1'b0, k_r};

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = S_CHECK;
      S_CHECK: state_nx = dims_bad ? S_DONE : S_ISSUE;
      S_ISSUE: state_nx = S_WAIT;
      S_WAIT:  if (tile_done) state_nx = S_NEXT;
      S_NEXT:  state_nx = (k_wrap && col_wrap && row_wrap) ? S_DONE : S_ISSUE;
      S_DONE:  if (start) state_nx = S_CHECK;
      default: state_nx = S_IDLE;
    endcase
    if (abort) state_nx = S_IDLE;
  end

  // Offsets of the tile about to be issued: k innermost, then col, then row.
  always_comb begin
    nrow = row_off;
    ncol = col_off;
    nk   = k_off;
    if (state == S_CHECK) begin
      nrow = '0;
      ncol = '0;
      nk   = '0;
    end else if (!k_wrap) begin
      nk = k_sum[DIM_W-1:0];
    end else begin
      nk = '0;
      if (!col_wrap) begin
        ncol = col_sum[DIM_W-1:0];
      end else begin
        ncol = '0;
        nrow = row_sum[DIM_W-1:0];
      end
    end
  end

  assign rem_r  = {1'b0, m_r} - {1'b0, nrow};
  assign rem_c  = {1'b0, n_r} - {1'b0, ncol};
  assign rem_k  = {1'b0, k_r} - {1'b0, nk};
  assign n_rows = (rem_r >= (DIM_W+1)'(ARRAY_W)) ? RW'(ARRAY_W) : rem_r[RW-1:0];
  assign n_cols = (rem_c >= (DIM_W+1)'(ARRAY_L)) ? CW'(ARRAY_L) : rem_c[CW-1:0];
  assign n_k    = (rem_k >= (DIM_W+1)'(ARRAY_K)) ? KW'(ARRAY_K) : rem_k[KW-1:0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      m_r       <= '0;
      k_r       <= '0;
      ww_r      <= '0;
      n_r       <= '0;
      row_off   <= '0;
      col_off   <= '0;
      k_off     <= '0;
      tile_rows <= '0;
      tile_cols <= '0;
      tile_k    <= '0;
      acc_clear <= 1'b0;
      acc_store <= 1'b0;
      err       <= 1'b0;
      tile_cnt  <= '0;
    end else begin
      state <= state_nx;
      if (take_start) begin
        m_r      <= ARRAY_A_W;
        k_r      <= ARRAY_A_L;
        ww_r     <= ARRAY_W_W;
        n_r      <= ARRAY_W_L;
        tile_cnt <= '0;
      end else if (state == S_WAIT && tile_done && !abort) begin
        tile_cnt <= tile_cnt + DIM_W'(1);
      end
      if (abort || take_start) err <= 1'b0;
      else if (state == S_CHECK && dims_bad) err <= 1'b1;
      // Fields load only on the edge into ISSUE, so they are stable otherwise.
      if (state_nx == S_ISSUE) begin
        row_off   <= nrow;
        col_off   <= ncol;
        k_off     <= nk;
        tile_rows <= n_rows;
        tile_cols <= n_cols;
        tile_k    <= n_k;
        acc_clear <= (nk == '0);
        acc_store <= (rem_k <= (DIM_W+1)'(ARRAY_K));
      end
    end
  end

  assign tile_start = (state == S_ISSUE);
  assign busy       = (state == S_CHECK) || (state == S_ISSUE) ||
                      (state == S_WAIT)  || (state == S_NEXT);
  assign ready      = (state == S_DONE);
  assign state_dbg  = state;
endmodule

// File: tb/tb_sys_array_tile_sched.sv
// Bench for sys_array_tile_sched: directed scenarios plus random jobs, each
// tile checked against a tile list built from nested loops over M, N, K.
module tb_sys_array_tile_sched;
  localparam int AW = 4;
  localparam int AL = 4;
  localparam int AK = 4;
  localparam int TW = 16 * 3 + 3 * 3 + 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        tile_done = 1'b0;
  logic [15:0] dim_m = '0, dim_k = '0, dim_ww = '0, dim_n = '0;
  logic        tile_start, acc_clear, acc_store, busy, ready, err;
  logic [15:0] row_off, col_off, k_off, tile_cnt;
  logic [2:0]  tile_rows, tile_cols, tile_k, state_dbg;

  logic [TW-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail = 0;

  sys_array_tile_sched dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .ARRAY_A_W(dim_m), .ARRAY_A_L(dim_k), .ARRAY_W_W(dim_ww), .ARRAY_W_L(dim_n),
    .tile_done(tile_done), .tile_start(tile_start),
    .row_off(row_off), .col_off(col_off), .k_off(k_off),
    .tile_rows(tile_rows), .tile_cols(tile_cols), .tile_k(tile_k),
    .acc_clear(acc_clear), .acc_store(acc_store), .busy(busy), .ready(ready),
    .err(err), .tile_cnt(tile_cnt), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s obs=%0h exp=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic [TW-1:0] pack_tile(input int r, input int c, input int k,
                                               input int rows, input int cols, input int tk,
                                               input bit clr, input bit st);
    return {16'(r), 16'(c), 16'(k), 3'(rows), 3'(cols), 3'(tk), clr, st};
  endfunction

  function automatic logic [TW-1:0] obs_tile();
    return pack_tile(row_off, col_off, k_off, tile_rows, tile_cols, tile_k, acc_clear, acc_store);
  endfunction

  // Reference: enumerate tiles row-major over (row, col) with k innermost.
  task automatic build_exp(input int m, input int k, input int ww, input int n,
                           output bit bad, output int passes);
    exp_q.delete();
    passes = 0;
    bad = (m == 0) || (k == 0) || (n == 0) || (ww != k);
    if (bad) return;
    for (int r = 0; r < m; r += AW)
      for (int c = 0; c < n; c += AL)
        for (int kk = 0; kk < k; kk += AK) begin
          exp_q.push_back(pack_tile(r, c, kk, imin(AW, m - r), imin(AL, n - c),
                                    imin(AK, k - kk), kk == 0, kk + AK >= k));
          passes++;
        end
  endtask

  // stop_pass>0 with stop_kind 1 = abort, 2 = reset, during WAIT of that pass.
  task automatic run_job(input int m, input int k, input int ww, input int n,
                         input int dly_lo, input int dly_hi, input bit spur,
                         input int stop_pass, input int stop_kind, input bit restart_mid);
    bit bad;
    int passes, pass_idx, guard, d;
    logic [TW-1:0] snap;
    build_exp(m, k, ww, n, bad, passes);
    dim_m = 16'(m); dim_k = 16'(k); dim_ww = 16'(ww); dim_n = 16'(n);
    start = 1'b1;
    step();
    start = 1'b0;
    check("busy_in_check", busy, 1'b1);
    pass_idx = 0;
    guard = 0;
    while (guard < 3000) begin
      if (tile_start) begin
        pass_idx++;
        if (pass_idx == 1) check("first_issue_latency", guard, 1);
        if (exp_q.size() == 0) check("extra_tile", 1, 0);
        else check($sformatf("tile%0d", pass_idx), obs_tile(), exp_q.pop_front());
        snap = obs_tile();
        if (spur) begin
          tile_done = 1'b1;
          step();
          tile_done = 1'b0;
        end else begin
          step();
        end
        if (stop_pass == pass_idx) begin
          if (stop_kind == 1) begin
            abort = 1'b1;
            tile_done = 1'b1;
            step();
            abort = 1'b0;
            tile_done = 1'b0;
            check("abort_busy", busy, 1'b0);
            check("abort_ready", ready, 1'b0);
            check("abort_tile_start", tile_start, 1'b0);
            check("abort_err", err, 1'b0);
            step();
            check("abort_stays_idle", {busy, ready, tile_start}, 3'b000);
          end else begin
            reset_n = 1'b0;
            #1;
            check("rst_flags", {tile_start, busy, ready, err, acc_clear, acc_store}, 6'b0);
            check("rst_fields", obs_tile(), '0);
            check("rst_tile_cnt", tile_cnt, 16'd0);
            step();
            check("rst_no_tile_start", tile_start, 1'b0);
            reset_n = 1'b1;
            step();
          end
          exp_q.delete();
          return;
        end
        if (restart_mid && pass_idx == 1) begin
          start = 1'b1;
          dim_m = 16'd7; dim_k = 16'd3; dim_ww = 16'd3; dim_n = 16'd9;
          step();
          start = 1'b0;
        end
        d = $urandom_range(dly_hi, dly_lo);
        repeat (d) begin
          step();
          guard++;
        end
        tile_done = 1'b1;
        step();
        tile_done = 1'b0;
        check("hold_fields", {tile_start, obs_tile()}, {1'b0, snap});
        step();
      end else if (ready) begin
        break;
      end else begin
        step();
      end
      guard++;
    end
    if (guard >= 3000) check("job_timeout", 0, 1);
    if (bad) check("err_latency", guard, 1);
    check("ready", ready, 1'b1);
    check("err", err, bad);
    check("busy_done", busy, 1'b0);
    check("tile_cnt", tile_cnt, 16'(passes));
    check("passes_left", exp_q.size(), 0);
  endtask

  initial begin
    int m, k, n, ww;
    step();
    check("reset_flags", {tile_start, busy, ready, err, acc_clear, acc_store}, 6'b0);
    check("reset_fields", obs_tile(), '0);
    check("reset_tile_cnt", tile_cnt, 16'd0);
    reset_n = 1'b1;
    step();
    check("idle_after_reset", {busy, ready}, 2'b00);

    run_job(5, 2, 2, 5, 0, 0, 1'b0, 0, 0, 1'b0);
    run_job(4, 9, 9, 4, 0, 0, 1'b0, 0, 0, 1'b0);
    run_job(2, 2, 3, 2, 0, 0, 1'b0, 0, 0, 1'b0);
    run_job(0, 2, 2, 2, 0, 0, 1'b0, 0, 0, 1'b0);
    run_job(5, 2, 2, 5, 7, 7, 1'b1, 0, 0, 1'b0);
    run_job(5, 2, 2, 5, 0, 2, 1'b0, 2, 1, 1'b0);
    run_job(5, 2, 2, 5, 0, 2, 1'b0, 0, 0, 1'b0);
    run_job(5, 6, 6, 9, 0, 2, 1'b0, 2, 2, 1'b0);
    run_job(5, 6, 6, 9, 0, 2, 1'b0, 0, 0, 1'b1);

    for (int i = 0; i < 10; i++) begin
      m  = $urandom_range(13, 0);
      k  = $urandom_range(13, 1);
      n  = $urandom_range(13, 1);
      ww = ($urandom_range(5, 0) == 0) ? k + 1 : k;
      run_job(m, k, ww, n, 0, 3, 1'($urandom_range(1, 0)), 0, 0, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
